// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational ripple-borrow subtractor used for the per-iteration trial
// subtract: diff = a - b, borrow_out set when b > a.
module div_trial_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    // One full-subtractor cell per bit, borrow rippling from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per
// clock, with a start/done handshake and divide-by-zero detection.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic             accept;
    logic             last;

    // Shift the next dividend bit into the partial remainder for the trial.
    assign t      = {r[WIDTH-1:0], q[WIDTH-1]};
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    div_trial_sub #(
        .N(WIDTH + 1)
    ) u_trial_sub (
        .a          (t),
        .b          ({1'b0, d}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Keep the difference when it did not go negative, otherwise restore.
    always_comb begin
        r_step = t;
        q_step = {q[WIDTH-2:0], 1'b0};
        if (!borrow) begin
            r_step = diff;
            q_step = {q[WIDTH-2:0], 1'b1};
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a zero divisor skips straight to DONE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d           <= divisor;
            q           <= dividend;
            r           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                quotient    <= ALL_ONES;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient  <= q_step;
                remainder <= r_step[WIDTH-1:0];
            end
        end
    end

endmodule
